// File: rtl/seg7_pkg.sv
// Glyph table and helpers shared by the seven-segment scan driver.
package seg7_pkg;

    // Active-high glyphs in {g,f,e,d,c,b,a} order
    localparam logic [6:0] GLYPH_0 = 7'b0111111;
    localparam logic [6:0] GLYPH_1 = 7'b0000110;
    localparam logic [6:0] GLYPH_2 = 7'b1011011;
    localparam logic [6:0] GLYPH_3 = 7'b1001111;
    localparam logic [6:0] GLYPH_4 = 7'b1100110;
    localparam logic [6:0] GLYPH_5 = 7'b1101101;
    localparam logic [6:0] GLYPH_6 = 7'b1111101;
    localparam logic [6:0] GLYPH_7 = 7'b0000111;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1101111;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b1111100;
    localparam logic [6:0] GLYPH_C = 7'b0111001;
    localparam logic [6:0] GLYPH_D = 7'b1011110;
    localparam logic [6:0] GLYPH_E = 7'b1111001;
    localparam logic [6:0] GLYPH_F = 7'b1110001;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Nibble to active-high hex glyph
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Per-digit combinational decoder: nibble to active-high glyph, forced dark when blanked.
module seg7_glyph_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered data, leading-zero
// blanking, per-digit decimal points, PWM brightness and a guard cycle per slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BRIGHT_BITS    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int SEL_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   bcd_input,
    input  logic [NUM_DIGITS-1:0]     dp_input,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [SEL_W-1:0]          digit_sel,
    output logic                      frame_tick
);

    localparam int                    PRE_W     = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0]      SLOT_LAST = SEL_W'(NUM_DIGITS - 1);
    // Inactive pin levels; XOR with these applies output polarity
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [PRE_W-1:0]                  presc;
    logic [SEL_W-1:0]                  slot;
    logic                              frame_end;

    logic [NUM_DIGITS-1:0][3:0]        pend_bcd;
    logic [NUM_DIGITS-1:0]             pend_dp;
    logic                              pend_vld;
    logic [NUM_DIGITS-1:0][3:0]        shadow_bcd;
    logic [NUM_DIGITS-1:0]             shadow_dp;

    logic [NUM_DIGITS-1:0]             lz_blank;
    logic                              zero_run;
    logic [NUM_DIGITS-1:0][6:0]        glyph;

    logic [PRE_W-1:0]                  on_cycles;
    logic                              lit;
    logic [6:0]                        seg_nxt;
    logic                              dp_nxt;
    logic [NUM_DIGITS-1:0]             an_nxt;

    // Frame boundary: last prescaler count of the last slot
    assign frame_end = (presc == PRE_LAST) && (slot == SLOT_LAST);

    // Prescaler and slot counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
            slot  <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            slot  <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Pending/shadow buffers; shadow only moves on the frame boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else if (frame_end) begin
            // A load landing on the boundary is newer than anything pending
            if (load) begin
                shadow_bcd <= bcd_input;
                shadow_dp  <= dp_input;
            end else if (pend_vld) begin
                shadow_bcd <= pend_bcd;
                shadow_dp  <= pend_dp;
            end
            pend_vld <= 1'b0;
        end else if (load) begin
            pend_bcd <= bcd_input;
            pend_dp  <= dp_input;
            pend_vld <= 1'b1;
        end
    end

    // Leading-zero mask: walk down from the top digit while digits stay zero; digit 0 never blanks
    always_comb begin
        lz_blank = '0;
        zero_run = blank_lz;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (shadow_bcd[k] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        seg7_glyph_decoder u_dec (
            .nibble (shadow_bcd[k]),
            .blank  (lz_blank[k]),
            .seg    (glyph[k])
        );
    end

    assign on_cycles = PRE_W'(brightness);

    // Current-slot selection; anode lit for prescaler 1..brightness, prescaler 0 is the guard
    always_comb begin
        seg_nxt      = glyph[slot];
        dp_nxt       = shadow_dp[slot];
        lit          = (presc != '0) && (presc <= on_cycles);
        an_nxt       = '0;
        an_nxt[slot] = lit;
    end

    // Output registers with polarity applied
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg        <= SEG_OFF;
            dp         <= SEG_ACTIVE_LOW;
            an         <= AN_OFF;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt ^ SEG_OFF;
            dp         <= dp_nxt ^ SEG_ACTIVE_LOW;
            an         <= an_nxt ^ AN_OFF;
            digit_sel  <= slot;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver (4 digits, 20-cycle slots, active-low pins).
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 20;
    localparam int FR = ND * RD;

    // Active-low glyphs, hand-inverted from the gfedcba table
    localparam logic [6:0] L0 = 7'b1000000;
    localparam logic [6:0] L1 = 7'b1111001;
    localparam logic [6:0] L2 = 7'b0100100;
    localparam logic [6:0] L3 = 7'b0110000;
    localparam logic [6:0] L4 = 7'b0011001;
    localparam logic [6:0] L5 = 7'b0010010;
    localparam logic [6:0] L6 = 7'b0000010;
    localparam logic [6:0] L7 = 7'b1111000;
    localparam logic [6:0] L8 = 7'b0000000;
    localparam logic [6:0] L9 = 7'b0010000;
    localparam logic [6:0] LA = 7'b0001000;
    localparam logic [6:0] LB = 7'b0000011;
    localparam logic [6:0] LC = 7'b1000110;
    localparam logic [6:0] LD = 7'b0100001;
    localparam logic [6:0] LE = 7'b0000110;
    localparam logic [6:0] LF = 7'b0001110;
    localparam logic [6:0] BK = 7'b1111111;

    typedef struct {
        logic [15:0]       bcd;
        logic [3:0]        dpi;
        logic              blz;
        logic [3:0]        br;
        logic [3:0][6:0]   exp_seg;   // indexed by slot
        logic [3:0]        exp_dp;    // pin level per slot
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_input;
    logic [3:0]  dp_input;
    logic        load;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[7];

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_BITS(4),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bcd_input(bcd_input), .dp_input(dp_input),
        .load(load), .blank_lz(blank_lz), .brightness(brightness),
        .seg(seg), .dp(dp), .an(an), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        bcd_input  = v.bcd;
        dp_input   = v.dpi;
        blank_lz   = v.blz;
        brightness = v.br;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    // Returns on the negedge where frame_tick is seen; next negedge is slot 0, prescaler 0
    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        check({name, " tick"}, 32'(frame_tick), 32'd1);
    endtask

    // Watch one full frame starting at slot 0 prescaler 0
    task automatic observe_frame(input vec_t v, input string tag);
        logic [19:0] mask, exp_mask;
        logic [3:0]  on_pat;
        int          other;
        exp_mask = 20'((32'd1 << (int'(v.br) + 1)) - 1) & ~20'd1;
        for (int s = 0; s < ND; s++) begin
            mask   = '0;
            other  = 0;
            on_pat = ~(4'b0001 << s);
            for (int p = 0; p < RD; p++) begin
                @(negedge clk);
                if (an === on_pat) mask[p] = 1'b1;
                else if (an !== 4'hF) other++;
                if (p == 1)  check($sformatf("%s s%0d seg_early", tag, s), 32'(seg), 32'(v.exp_seg[s]));
                if (p == 19) check($sformatf("%s s%0d seg_late", tag, s), 32'(seg), 32'(v.exp_seg[s]));
                if (p == 10) begin
                    check($sformatf("%s s%0d dp", tag, s), 32'(dp), 32'(v.exp_dp[s]));
                    check($sformatf("%s s%0d digit_sel", tag, s), 32'(digit_sel), 32'(s));
                end
            end
            check($sformatf("%s s%0d an_mask", tag, s), 32'(mask), 32'(exp_mask));
            check($sformatf("%s s%0d an_other", tag, s), 32'(other), 32'd0);
        end
    endtask

    initial begin : main
        vec_t v;
        int   cnt;
        int   a_seen;

        vecs[0] = '{bcd:16'h1234, dpi:4'b0010, blz:1'b0, br:4'd15, exp_seg:{L1, L2, L3, L4}, exp_dp:4'b1101};
        vecs[1] = '{bcd:16'h0042, dpi:4'b0000, blz:1'b1, br:4'd15, exp_seg:{BK, BK, L4, L2}, exp_dp:4'b1111};
        vecs[2] = '{bcd:16'h0000, dpi:4'b0000, blz:1'b1, br:4'd15, exp_seg:{BK, BK, BK, L0}, exp_dp:4'b1111};
        vecs[3] = '{bcd:16'h5678, dpi:4'b1001, blz:1'b0, br:4'd4,  exp_seg:{L5, L6, L7, L8}, exp_dp:4'b0110};
        vecs[4] = '{bcd:16'h0000, dpi:4'b0000, blz:1'b0, br:4'd0,  exp_seg:{L0, L0, L0, L0}, exp_dp:4'b1111};
        vecs[5] = '{bcd:16'h0100, dpi:4'b1000, blz:1'b1, br:4'd7,  exp_seg:{BK, L1, L0, L0}, exp_dp:4'b0111};
        vecs[6] = '{bcd:16'hCDEF, dpi:4'b0000, blz:1'b1, br:4'd1,  exp_seg:{LC, LD, LE, LF}, exp_dp:4'b1111};

        reset = 1'b0; bcd_input = '0; dp_input = '0; load = 1'b0;
        blank_lz = 1'b0; brightness = 4'd15;

        // Power-on reset state
        repeat (3) @(negedge clk);
        check("rst an", 32'(an), 32'hF);
        check("rst seg", 32'(seg), 32'h7F);
        check("rst dp", 32'(dp), 32'd1);
        check("rst frame_tick", 32'(frame_tick), 32'd0);
        check("rst digit_sel", 32'(digit_sel), 32'd0);
        reset = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < 200);
        check("rst first_tick_cycles", 32'(cnt), 32'd80);

        // Table: load, wait for the boundary, watch one frame
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i]);
            wait_tick($sformatf("v%0d", i));
            observe_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Double buffering: two loads mid-frame, only the last one appears after the boundary
        v = '{bcd:16'h1234, dpi:4'b0000, blz:1'b0, br:4'd15, exp_seg:{L1, L2, L3, L4}, exp_dp:4'b1111};
        apply(v);
        wait_tick("db pre");
        a_seen = 0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            if (seg === LA) a_seen++;
            if (i == 10) begin bcd_input = 16'hAAAA; load = 1'b1; end
            if (i == 11) load = 1'b0;
            if (i == 30) begin bcd_input = 16'hBEEF; load = 1'b1; end
            if (i == 31) load = 1'b0;
            if (i == 5)  check("db hold s0", 32'(seg), 32'(L4));
            if (i == 35) check("db hold s1", 32'(seg), 32'(L3));
            if (i == 75) check("db hold s3", 32'(seg), 32'(L1));
            if (i == FR - 1) check("db tick", 32'(frame_tick), 32'd1);
        end
        check("db no_AAAA_in_old_frame", 32'(a_seen), 32'd0);
        v = '{bcd:16'hBEEF, dpi:4'b0000, blz:1'b0, br:4'd15, exp_seg:{LB, LE, LE, LF}, exp_dp:4'b1111};
        observe_frame(v, "db new");

        // Load on the boundary cycle itself goes straight to the displayed frame
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            if (i == FR - 2) begin bcd_input = 16'h9876; load = 1'b1; end
            if (i == FR - 1) begin
                load = 1'b0;
                check("bnd tick", 32'(frame_tick), 32'd1);
            end
        end
        v = '{bcd:16'h9876, dpi:4'b0000, blz:1'b0, br:4'd15, exp_seg:{L9, L8, L7, L6}, exp_dp:4'b1111};
        observe_frame(v, "bnd");

        // Reset mid-frame with a load pending: pending data must be dropped
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 5)  begin bcd_input = 16'h9999; dp_input = 4'hF; load = 1'b1; end
            if (i == 6)  load = 1'b0;
            if (i == 10) reset = 1'b0;
            if (i == 11) begin
                check("mid rst an", 32'(an), 32'hF);
                check("mid rst seg", 32'(seg), 32'h7F);
                check("mid rst dp", 32'(dp), 32'd1);
                check("mid rst frame_tick", 32'(frame_tick), 32'd0);
                check("mid rst digit_sel", 32'(digit_sel), 32'd0);
            end
            if (i == 13) reset = 1'b1;
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < 200);
        check("mid rst first_tick_cycles", 32'(cnt), 32'd80);
        v = '{bcd:16'h0000, dpi:4'b0000, blz:1'b0, br:4'd15, exp_seg:{L0, L0, L0, L0}, exp_dp:4'b1111};
        observe_frame(v, "mid rst after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
